// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_rx_pkg;

    localparam int unsigned BITS_DEFAULT = 8;
    localparam logic        IDLE_LEVEL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_hold_reg.sv
// Output holding register: owns the received word, its valid/ready handshake
// and overrun detection when a new word arrives before the old one is taken.
module rx_hold_reg
    import serial_rx_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [BITS-1:0] load_data,
    input  logic            data_ready,
    output logic [BITS-1:0] data_out,
    output logic            data_valid,
    output logic            overrun
);

    logic consume_c;

    assign consume_c = data_valid & data_ready;

    // A word taken on the same edge as a new completion makes room for it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!data_valid || consume_c) begin
                    data_out   <= load_data;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume_c) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Strobed serial frame receiver (start, LSB-first data, stop).
// Define SER_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            bit_en,
    input  logic            ser_in,
    output logic [BITS-1:0] data_out,
    output logic            data_valid,
    input  logic            data_ready,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
`ifdef SER_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

    rx_state_e       state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [BITS-1:0] shifter, shifter_next;
    logic            frame_err_next;
    logic            word_done_c;
`ifdef SER_RX_PARITY_EN
    logic            parity_bad, parity_bad_next;
    logic            parity_err_next;
`endif

    // Next-state, datapath and pulse decode; everything holds when bit_en=0.
    always_comb begin
        state_next     = state;
        count_next     = count;
        shifter_next   = shifter;
        frame_err_next = 1'b0;
        word_done_c    = 1'b0;
`ifdef SER_RX_PARITY_EN
        parity_bad_next = parity_bad;
        parity_err_next = 1'b0;
`endif
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (ser_in != IDLE_LEVEL) begin
                        state_next   = DATA;
                        count_next   = '0;
                        shifter_next = '0;
`ifdef SER_RX_PARITY_EN
                        parity_bad_next = 1'b0;
`endif
                    end
                end
                DATA: begin
                    shifter_next[count] = ser_in;
                    count_next          = count + CW'(1);
                    if (count == CW'(BITS - 1)) begin
`ifdef SER_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef SER_RX_PARITY_EN
                PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if (ser_in != ^shifter) begin
                        parity_err_next = 1'b1;
                        parity_bad_next = 1'b1;
                    end
                    state_next = STOP;
                end
`endif
                STOP: begin
                    if (ser_in == IDLE_LEVEL) begin
                        state_next = IDLE;
`ifdef SER_RX_PARITY_EN
                        word_done_c = !parity_bad;
`else
                        word_done_c = 1'b1;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
                BREAK: begin
                    // Wait for the line to return high so a held-low line never restarts.
                    if (ser_in == IDLE_LEVEL) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            shifter   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            count     <= count_next;
            shifter   <= shifter_next;
            frame_err <= frame_err_next;
            busy      <= (state_next != IDLE);
`ifdef SER_RX_PARITY_EN
            parity_bad <= parity_bad_next;
            parity_err <= parity_err_next;
`endif
        end
    end

    rx_hold_reg #(
        .BITS (BITS)
    ) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (word_done_c),
        .load_data  (shifter),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: directed scenarios plus random frames.
`timescale 1ns/1ps
module tb_serial_frame_receiver;

    localparam int unsigned BITS = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            bit_en;
    logic            ser_in;
    logic            data_ready;
    logic [BITS-1:0] data_out;
    logic            data_valid;
    logic            frame_err;
    logic            overrun;
    logic            busy;
`ifdef SER_RX_PARITY_EN
    logic            parity_err;
    int              pe_seen = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int gap_min = 0;
    int gap_max = 0;
    bit rand_ready = 1'b0;
    logic [BITS-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_frame_receiver #(.BITS(BITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_en     (bit_en),
        .ser_in     (ser_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef SER_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (frame_err === 1'b1) fe_seen++;
            if (overrun === 1'b1) ov_seen++;
`ifdef SER_RX_PARITY_EN
            if (parity_err === 1'b1) pe_seen++;
`endif
            if (data_valid === 1'b1 && data_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    check("word", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) data_ready = ($urandom_range(3, 0) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic send_sample(input logic b);
        int g;
        g = int'($urandom_range(gap_max, gap_min));
        repeat (g) begin
            bit_en = 1'b0;
            ser_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        ser_in = b;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        ser_in = 1'b1;
    endtask

    task automatic send_head(input logic [BITS-1:0] d);
        send_sample(1'b0);
        for (int i = 0; i < int'(BITS); i++) send_sample(d[i]);
    endtask

`ifdef SER_RX_PARITY_EN
    task automatic send_parity(input logic [BITS-1:0] d, input logic good);
        send_sample(good ? ^d : ~(^d));
    endtask
`endif

    task automatic send_good(input logic [BITS-1:0] d);
        send_head(d);
`ifdef SER_RX_PARITY_EN
        send_parity(d, 1'b1);
`endif
        send_sample(1'b1);
    endtask

    initial begin
        int fe0;
        int ov0;
        int exp_fe;
        logic [BITS-1:0] d;
        logic stop_ok;
        logic par_good;
        logic [BITS-1:0] sparse_word;
`ifdef SER_RX_PARITY_EN
        int pe0;
        int exp_pe;
`endif
        reset_n    = 1'b0;
        bit_en     = 1'b0;
        ser_in     = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic byte, one clk latency after the stop sample.
        exp_q.push_back(8'hA5);
        send_good(8'hA5);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_data_valid", 32'(data_valid), 32'h1);
        check("a5_busy", 32'(busy), 32'h0);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("a5_consumed", 32'(data_valid), 32'h0);

        // Sparse strobe: bit_en every third clock, with a long hold mid-frame.
        gap_min = 2;
        gap_max = 2;
        sparse_word = 8'hA5;
        exp_q.push_back(sparse_word);
        send_sample(1'b0);
        for (int i = 0; i < 4; i++) send_sample(sparse_word[i]);
        repeat (5) @(posedge clk);
        #1;
        check("sparse_hold_busy", 32'(busy), 32'h1);
        for (int i = 4; i < int'(BITS); i++) send_sample(sparse_word[i]);
`ifdef SER_RX_PARITY_EN
        send_parity(sparse_word, 1'b1);
`endif
        send_sample(1'b1);
        check("sparse_data_out", 32'(data_out), 32'hA5);
        check("sparse_data_valid", 32'(data_valid), 32'h1);
        gap_min = 0;
        gap_max = 0;
        repeat (2) @(posedge clk);
        #1;

        // Framing error, held-low line stays in BREAK.
        fe0 = fe_seen;
        send_head(8'h3C);
`ifdef SER_RX_PARITY_EN
        send_parity(8'h3C, 1'b1);
`endif
        send_sample(1'b0);
        check("ferr_pulse", 32'(frame_err), 32'h1);
        check("ferr_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            send_sample(1'b0);
            check("break_busy", 32'(busy), 32'h1);
        end
        check("ferr_one_cycle", 32'(frame_err), 32'h0);
        send_sample(1'b1);
        check("break_exit_busy", 32'(busy), 32'h0);
        check("ferr_count", 32'(fe_seen - fe0), 32'h1);
        check("ferr_no_valid", 32'(data_valid), 32'h0);

        // Overrun: second word dropped while the first is held.
        data_ready = 1'b0;
        ov0 = ov_seen;
        exp_q.push_back(8'h11);
        send_good(8'h11);
        send_good(8'h22);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_kept_old", 32'(data_out), 32'h11);
        @(posedge clk);
        #1;
        check("ovr_one_cycle", 32'(overrun), 32'h0);
        check("ovr_count", 32'(ov_seen - ov0), 32'h1);

        // Completion on the same edge as consumption: no overrun.
        ov0 = ov_seen;
        send_head(8'h22);
`ifdef SER_RX_PARITY_EN
        send_parity(8'h22, 1'b1);
`endif
        data_ready = 1'b1;
        exp_q.push_back(8'h22);
        send_sample(1'b1);
        check("same_edge_data", 32'(data_out), 32'h22);
        check("same_edge_valid", 32'(data_valid), 32'h1);
        check("same_edge_no_ovr", 32'(overrun), 32'h0);
        @(posedge clk);
        #1;
        check("same_edge_ovr_count", 32'(ov_seen - ov0), 32'h0);

        // Reset mid-frame with a held word, then a clean frame.
        data_ready = 1'b0;
        send_good(8'h99);
        check("pre_reset_held", 32'(data_out), 32'h99);
        send_sample(1'b0);
        for (int i = 0; i < 4; i++) send_sample(1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_data_out", 32'(data_out), 32'h0);
        check("midreset_valid", 32'(data_valid), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_ferr", 32'(frame_err), 32'h0);
        check("midreset_ovr", 32'(overrun), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        data_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_good(8'h5A);
        check("post_reset_data", 32'(data_out), 32'h5A);
        check("post_reset_valid", 32'(data_valid), 32'h1);

`ifdef SER_RX_PARITY_EN
        // Parity: 0x07 has three ones, so even parity bit is 1.
        exp_q.push_back(8'h07);
        send_head(8'h07);
        send_sample(1'b1);
        send_sample(1'b1);
        check("par_ok_data", 32'(data_out), 32'h07);
        check("par_ok_valid", 32'(data_valid), 32'h1);
        pe0 = pe_seen;
        send_head(8'h07);
        send_sample(1'b0);
        check("par_err_pulse", 32'(parity_err), 32'h1);
        send_sample(1'b1);
        check("par_err_no_valid", 32'(data_valid), 32'h0);
        check("par_err_count", 32'(pe_seen - pe0), 32'h1);
`endif

        // Random frames with random strobe gaps and a random consumer.
        gap_min = 0;
        gap_max = 2;
        rand_ready = 1'b1;
        fe0 = fe_seen;
        ov0 = ov_seen;
        exp_fe = 0;
`ifdef SER_RX_PARITY_EN
        pe0 = pe_seen;
        exp_pe = 0;
`endif
        for (int f = 0; f < 200; f++) begin
            d = BITS'($urandom);
            stop_ok = ($urandom_range(4, 0) != 0);
            par_good = 1'b1;
`ifdef SER_RX_PARITY_EN
            par_good = ($urandom_range(3, 0) != 0);
            if (!par_good) exp_pe++;
`endif
            if (stop_ok && par_good) exp_q.push_back(d);
            if (!stop_ok) exp_fe++;
            send_head(d);
`ifdef SER_RX_PARITY_EN
            send_parity(d, par_good);
`endif
            send_sample(stop_ok);
            if (!stop_ok) begin
                repeat ($urandom_range(4, 0)) send_sample(1'b0);
                send_sample(1'b1);
            end
            repeat ($urandom_range(3, 0)) send_sample(1'b1);
        end
        rand_ready = 1'b0;
        data_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rand_drained", 32'(exp_q.size()), 32'h0);
        check("rand_ferr_count", 32'(fe_seen - fe0), 32'(exp_fe));
        check("rand_ovr_count", 32'(ov_seen - ov0), 32'h0);
        check("rand_idle_busy", 32'(busy), 32'h0);
`ifdef SER_RX_PARITY_EN
        check("rand_perr_count", 32'(pe_seen - pe0), 32'(exp_pe));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter BITS, default 8: number of data bits per frame.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port bit_en, input, 1: sample strobe; the serial line is sampled only on clk edges where bit_en=1.
REQ-005 SHALL have port ser_in, input, 1: serial line; idles high; bits are sent LSB first.
REQ-006 SHALL have port data_out, output, BITS: the received word.
REQ-007 SHALL have port data_valid, output, 1: data_out holds an unconsumed word.
REQ-008 SHALL have port data_ready, input, 1: consumer accepts the word.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when a completed word is dropped.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 Frame format SHALL be: start bit 0, then BITS data bits LSB first, then an optional parity bit (REQ-028), then stop bit 1.
REQ-013 State machine SHALL use the states IDLE, DATA, PARITY, STOP and BREAK.
REQ-014 IDLE: a sampled 0 SHALL clear the bit counter and move to DATA.
REQ-015 DATA: each sample SHALL shift into bit position count, which then increments.
REQ-016 DATA: after sample BITS-1, the state SHALL move to PARITY if enabled, else to STOP.
REQ-017 STOP: a sample of 1 SHALL complete the word and return to IDLE.
REQ-018 STOP: a sample of 0 SHALL pulse frame_err, discard the word and move to BREAK.
REQ-019 BREAK: the state SHALL stay in BREAK until a sample of 1, then return to IDLE, so a held-low line never re-triggers a start.
REQ-020 Cycles with bit_en=0 SHALL hold all state, except handshake and pulse outputs.
REQ-021 On the completing edge, data_out SHALL load and data_valid SHALL rise; the word is visible in the next cycle (latency 1 clk after the stop sample).
REQ-022 Handshake: a word SHALL be consumed on an edge with data_valid=1 and data_ready=1; data_valid then falls unless REQ-023 applies.
REQ-023 Completion and consumption on the same edge: the new word SHALL load, data_valid SHALL stay 1 and no overrun SHALL be signalled.
REQ-024 Completion while data_valid=1 and data_ready=0: the old word SHALL be kept, the new word dropped and overrun pulsed for 1 cycle.
REQ-025 data_out SHALL stay stable while data_valid=1 and data_ready=0.

Reset
REQ-026 While reset_n=0, the following SHALL apply:
- state = IDLE;
- counter and shifter cleared;
- data_out = 0;
- data_valid, frame_err, overrun, busy = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no error pulse, and reception SHALL resume from IDLE after release.

Configuration
REQ-028 With SER_RX_PARITY_EN defined, the following SHALL apply:
- a PARITY state samples one even-parity bit after the data bits;
- a mismatch pulses output parity_err for 1 cycle and discards the word;
- the stop bit is still checked.
REQ-029 Without SER_RX_PARITY_EN, the PARITY state and the parity_err port SHALL be absent, and DATA SHALL go straight to STOP.

Structure
REQ-030 Package serial_rx_pkg SHALL hold:
- the state enum (IDLE, DATA, PARITY, STOP, BREAK);
- the BITS default constant;
- the idle-level constant (1).
REQ-031 One sub-module, rx_hold_reg, SHALL own data_out, data_valid, the handshake and overrun detection; the state machine and shifter SHALL stay in the top module.

Verification
REQ-032 Byte received: BITS=8, bit_en=1, ser_in = 0, 1,0,1,0,0,1,0,1, 1 -> data_out=0xA5 and data_valid=1 one clk after the stop sample; busy=0.
REQ-033 Sparse strobe: same frame with bit_en=1 on every 3rd clk -> data_out=0xA5; state unchanged on bit_en=0 cycles.
REQ-034 Framing error: frame 0x3C with stop bit=0, then line held 0 for 5 samples, then 1 -> frame_err pulses once, data_valid stays 0, state is BREAK until the 1, then IDLE.
REQ-035 Overrun and back-to-back frames:
- frames 0x11 then 0x22 with data_ready=0 -> data_out=0x11 and overrun pulses once;
- repeat with data_ready=1 on the 0x22 completion edge -> data_out=0x22, data_valid stays 1, no overrun.
REQ-036 Reset mid-frame: reset_n low after 4 data bits -> all outputs 0 and state IDLE; the following frame 0x5A is received correctly.
REQ-037 With SER_RX_PARITY_EN defined:
- frame 0x07 with parity bit 1 -> accepted;
- frame 0x07 with parity bit 0 -> parity_err pulses and data_valid stays 0.
